// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester and ALU bus of the shared-ALU arbiter
interface alu_share_arbiter_if #(
   parameter int N = 3,
   parameter int W = 32
);
   localparam int OW = (N > 1) ? $clog2(N) : 1;

   // requester side
   logic [N-1:0]   req_i;
   logic [N-1:0]   lock_i;
   logic [3*N-1:0] op_i;
   logic [W*N-1:0] a_i;
   logic [W*N-1:0] b_i;
   logic [N-1:0]   gnt_o;
   logic [N-1:0]   done_o;
   logic [W-1:0]   res_o;
   logic [OW-1:0]  owner_o;
   logic           busy_o;

   // shared ALU side
   logic [W-1:0]   alu_res_i;
   logic [2:0]     alu_op_o;
   logic [W-1:0]   alu_a_o;
   logic [W-1:0]   alu_b_o;

   modport slave (
      input  req_i, lock_i, op_i, a_i, b_i, alu_res_i,
      output gnt_o, done_o, res_o, owner_o, busy_o, alu_op_o, alu_a_o, alu_b_o
   );

   modport master (
      output req_i, lock_i, op_i, a_i, b_i, alu_res_i,
      input  gnt_o, done_o, res_o, owner_o, busy_o, alu_op_o, alu_a_o, alu_b_o
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter with owner lock for one shared ALU
module alu_share_arbiter #(
   parameter int N = 3,
   parameter int W = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   alu_share_arbiter_if.slave bus
);
   localparam int OW = $clog2(N);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [OW-1:0]  owner;
   logic [OW-1:0]  rr_ptr;
   logic           locked;
   logic           issue;
   logic [OW-1:0]  winner;
   logic [N-1:0]   req_rot;
   logic [OW:0]    idx_sum;
   logic [2:0]     win_op;
   logic [W-1:0]   win_a;
   logic [W-1:0]   win_b;
   logic [N-1:0]   win_oh;
   logic [N-1:0]   owner_oh;
   logic           owner_lock;

   function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] v);
      return (v == OW'(N - 1)) ? '0 : v + OW'(1);
   endfunction

   // Pick the winner: the lock owner only, else the first request at or after rr_ptr.
   always_comb begin
      issue   = 1'b0;
      winner  = owner;
      idx_sum = '0;
      req_rot = N'({bus.req_i, bus.req_i} >> rr_ptr);
      if (locked) begin
         issue = bus.req_i[owner];
      end else begin
         // descending scan so the lowest rotated offset is the last one written
         for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
               issue   = 1'b1;
               idx_sum = {1'b0, rr_ptr} + (OW + 1)'(i);
               if (idx_sum >= (OW + 1)'(N)) begin
                  idx_sum = idx_sum - (OW + 1)'(N);
               end
               winner = idx_sum[OW-1:0];
            end
         end
      end
   end

   // Steer the winner's opcode/operands and form the one-hot vectors.
   always_comb begin
      win_op = '0;
      win_a  = '0;
      win_b  = '0;
      for (int k = 0; k < N; k++) begin
         if (winner == OW'(k)) begin
            win_op = bus.op_i[3*k +: 3];
            win_a  = bus.a_i[W*k +: W];
            win_b  = bus.b_i[W*k +: W];
         end
      end
      win_oh     = N'(1) << winner;
      owner_oh   = N'(1) << owner;
      owner_lock = bus.lock_i[owner];
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: every issue is followed by exactly one EXEC cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = EXEC;
         EXEC:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs derived directly from state and the owner register.
   always_comb begin
      bus.busy_o  = (state == EXEC);
      bus.owner_o = owner;
   end

   // Registered datapath: ALU inputs on issue, result and done one cycle later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus.alu_op_o <= '0;
         bus.alu_a_o  <= '0;
         bus.alu_b_o  <= '0;
         bus.gnt_o    <= '0;
         bus.done_o   <= '0;
         bus.res_o    <= '0;
         owner        <= '0;
         rr_ptr       <= '0;
         locked       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done_o <= '0;
               bus.gnt_o  <= issue ? win_oh : '0;
               if (issue) begin
                  bus.alu_op_o <= win_op;
                  bus.alu_a_o  <= win_a;
                  bus.alu_b_o  <= win_b;
                  owner        <= winner;
               end
               // an idle owner may drop its lock; takes effect from the next cycle
               if (locked && !owner_lock) begin
                  locked <= 1'b0;
                  rr_ptr <= next_idx(owner);
               end
            end
            EXEC: begin
               bus.res_o  <= bus.alu_res_i;
               bus.done_o <= owner_oh;
               bus.gnt_o  <= '0;
               locked     <= owner_lock;
               if (!owner_lock) begin
                  rr_ptr <= next_idx(owner);
               end
            end
            default: begin
               bus.gnt_o  <= '0;
               bus.done_o <= '0;
            end
         endcase
      end
   end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter that time-shares the single combinational ALU between up to N sequencing engines: the multiplier, the square-root engine and the top-level hypotenuse controller. Each requester presents an operation and two operands. The arbiter registers the winner's request onto the ALU inputs, captures the ALU result one cycle later and returns it with a one-cycle done pulse. A per-requester lock lets an engine hold the ALU across a multi-step sequence, for example an 8-iteration shift-add multiply.

## Interface
Parameters:
- N, 3: number of requesters, 2..8.
- W, 32: operand/result width.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- req_i, in, N: request per requester.
- lock_i, in, N: keep ownership after the current operation.
- op_i, in, 3N: ALU opcode, requester k at [3k+2:3k].
- a_i, in, W·N: operand A, requester k at [W(k+1)-1:Wk].
- b_i, in, W·N: operand B, same packing as a_i.
- alu_res_i, in, W: combinational result from the shared ALU.
- alu_op_o, out, 3: registered opcode to the ALU.
- alu_a_o, out, W: registered operand A to the ALU.
- alu_b_o, out, W: registered operand B to the ALU.
- gnt_o, out, N: one-hot; asserted for the single cycle in which operands are on the ALU.
- done_o, out, N: one-hot, single-cycle pulse; res_o is valid to that requester.
- res_o, out, W: registered ALU result, holds until the next done.
- owner_o, out, clog2(N): index of the last or current owner.
- busy_o, out, 1: high in EXEC.

## Operation
- States: IDLE, EXEC.
- Reset values: state IDLE, all outputs 0, rr_ptr 0, locked 0, owner 0.
- IDLE, with `locked`=1:
  - only owner may win;
  - if req_i[owner]=1, issue owner;
  - otherwise issue nothing and stay IDLE;
  - other requests wait.
- IDLE, with `locked`=0:
  - winner = first k with req_i[k]=1, searching rr_ptr, rr_ptr+1, … modulo N;
  - no request: stay IDLE, ALU outputs hold their previous values.
- Issue:
  - alu_op_o/alu_a_o/alu_b_o <= winner's slices;
  - gnt_o <= onehot(winner);
  - owner <= winner;
  - go to EXEC.
- EXEC:
  - res_o <= alu_res_i;
  - done_o <= onehot(owner);
  - gnt_o <= 0;
  - locked <= lock_i[owner];
  - if lock_i[owner]=0, rr_ptr <= (owner+1) mod N, otherwise rr_ptr unchanged;
  - go to IDLE.
- Releasing a lock while the owner is idle:
  - lock_i[owner] is also sampled every IDLE cycle;
  - if it reads 0, locked clears and rr_ptr <= (owner+1) mod N that same cycle;
  - that cycle still arbitrates with the old locked value.
- req_i, op_i and the operands are not sampled in EXEC.
  - A requester must hold op/operands stable from req assertion until it sees gnt_o.
  - It may drop req in the gnt_o cycle.
  - A req still high when the FSM is back in IDLE counts as a new request.
- Arithmetic: the arbiter does no arithmetic; values pass through at W bits unmodified.
- Opcode values (000 add, 100 sub, etc.) are opaque to this block.
- Reset mid-EXEC: the operation is discarded, no done_o pulse is emitted, and ownership/lock clear.

## Timing
- Request high before edge E (state IDLE) → gnt_o and ALU inputs valid in cycle E..E+1.
- done_o and res_o are valid in the following cycle, so latency is 2 clocks from sampling to done.
- Throughput: one operation per 2 cycles, including for a locked owner issuing back-to-back.
- done_o is exactly 1 cycle wide.
- gnt_o and done_o are never high in the same cycle.
- Simultaneous requests resolve in a single cycle; no bubble between one owner's done cycle and the next IDLE arbitration.
- With all N requesting continuously and no locks, each requester is served once per 2N cycles.
- Between operations, ALU inputs change only on an issue edge.

## Test plan
- Single op, N=3: requester 1 drives op=000, a=5, b=7 → gnt_o=010 one cycle later, then done_o=010 with res_o=12 (ALU model is an adder); busy_o high for exactly 1 cycle.
- All three request continuously, no lock, from reset → grant order 0,1,2,0,1,2, each done 2 cycles apart.
- Lock sequence: requester 2 does 8 ops with lock_i[2]=1 while 0 and 1 request → 8 consecutive grants to 2, then lock_i[2]=0 → next grant goes to 0 (rr_ptr=0).
- Locked owner idles 5 cycles with lock high → no grants to anyone and ALU outputs stable; then lock drops → requester (owner+1) mod 3 is served next.
- Async rst_i pulse mid-EXEC → all outputs 0 immediately, no done pulse; after release, a pending request from 0 is served first.
- Request drops on the same edge it would be sampled, with no other requests → no issue; FSM stays IDLE and outputs hold.
